// File: rtl/dcd_var_ctrl.sv
// dcd_var_ctrl: decision controller fed by the state_list find-first-free chain.
// On a start request it samples the chain's one-hot index and lock count, validates
// them, and writes a decision value into the chosen variable slot at level cur_lvl+1.
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   start_dcd_i         single-cycle decision request (honoured only when idle)
//   index_i, lock_cnt_i one-hot first-free index and final lock count from the chain
//   bkt_en_i, bkt_lvl_i backtrack strobe and level to restore
//   var_wr_en_o         one-hot write strobe (suppressed by a same-cycle backtrack or reset)
//   var_value_o         decision value {DCD_POL, 1'b0}
//   var_lvl_o           level written with the decision
//   dcd_idx_o           binary index of the last decided variable
//   cur_lvl_o           current decision level
//   busy_o              high while a decision is in flight
//   done_dcd_o          pulse after a decision is written
//   all_assigned_o      pulse when no free variable exists
//   lvl_ovf_o           pulse when the level range is exhausted
//   idx_err_o           pulse when the sampled index is not one-hot
module dcd_var_ctrl #(
  parameter int unsigned NUM_VARS  = 8,
  parameter int unsigned WIDTH_VAR = 3,
  parameter int unsigned WIDTH_LVL = 8,
  parameter logic [1:0]  DCD_POL   = 2'b01,
  localparam int unsigned IDX_W    = (NUM_VARS > 1) ? $clog2(NUM_VARS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_dcd_i,
  input  logic [NUM_VARS-1:0]  index_i,
  input  logic [1:0]           lock_cnt_i,
  input  logic                 bkt_en_i,
  input  logic [WIDTH_LVL-1:0] bkt_lvl_i,
  output logic [NUM_VARS-1:0]  var_wr_en_o,
  output logic [WIDTH_VAR-1:0] var_value_o,
  output logic [WIDTH_LVL-1:0] var_lvl_o,
  output logic [IDX_W-1:0]     dcd_idx_o,
  output logic [WIDTH_LVL-1:0] cur_lvl_o,
  output logic                 busy_o,
  output logic                 done_dcd_o,
  output logic                 all_assigned_o,
  output logic                 lvl_ovf_o,
  output logic                 idx_err_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SAMPLE = 3'd1,
    S_CHECK  = 3'd2,
    S_WRITE  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [WIDTH_VAR-1:0] DCD_VALUE = WIDTH_VAR'({DCD_POL, 1'b0});
  localparam logic [WIDTH_LVL-1:0] LVL_MAX   = {WIDTH_LVL{1'b1}};

  state_t               state_q, state_d;
  logic [NUM_VARS-1:0]  idx_q, idx_d;
  logic [1:0]           lock_q, lock_d;
  logic [WIDTH_LVL-1:0] cur_lvl_q, cur_lvl_d;
  logic [IDX_W-1:0]     dcd_idx_q, dcd_idx_d;
  logic [NUM_VARS-1:0]  wr_en_q, wr_en_d;
  logic [WIDTH_VAR-1:0] value_q, value_d;
  logic [WIDTH_LVL-1:0] lvl_q, lvl_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 all_q, all_d;
  logic                 ovf_q, ovf_d;
  logic                 err_q, err_d;
  logic                 no_free_c;
  logic                 multi_hot_c;

  // One-hot to binary; a malformed index never reaches the encoder.
  function automatic logic [IDX_W-1:0] encode(input logic [NUM_VARS-1:0] v);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < NUM_VARS; i++) begin
      if (v[i]) r = r | IDX_W'(i);
    end
    return r;
  endfunction

  // Captured chain result classification.
  assign no_free_c   = (lock_q == 2'b00) || (idx_q == '0);
  assign multi_hot_c = (idx_q & (idx_q - NUM_VARS'(1))) != '0;

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    lock_d    = lock_q;
    cur_lvl_d = cur_lvl_q;
    dcd_idx_d = dcd_idx_q;
    wr_en_d   = '0;
    value_d   = '0;
    lvl_d     = '0;
    done_d    = 1'b0;
    all_d     = 1'b0;
    ovf_d     = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Backtrack takes precedence over a simultaneous start.
        if (bkt_en_i) cur_lvl_d = bkt_lvl_i;
        else if (start_dcd_i) state_d = S_SAMPLE;
      end
      S_SAMPLE: begin
        idx_d   = index_i;
        lock_d  = lock_cnt_i;
        state_d = S_CHECK;
      end
      S_CHECK: begin
        state_d = S_IDLE;
        if (no_free_c) begin
          all_d = 1'b1;
        end else if (multi_hot_c) begin
          err_d = 1'b1;
        end else if (cur_lvl_q == LVL_MAX) begin
          ovf_d = 1'b1;
        end else begin
          state_d = S_WRITE;
          wr_en_d = idx_q;
          value_d = DCD_VALUE;
          lvl_d   = cur_lvl_q + WIDTH_LVL'(1);
        end
      end
      S_WRITE: begin
        cur_lvl_d = cur_lvl_q + WIDTH_LVL'(1);
        dcd_idx_d = encode(idx_q);
        done_d    = 1'b1;
        state_d   = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Backtrack while busy aborts the decision and wins over any increment.
    if (bkt_en_i && (state_q != S_IDLE)) begin
      state_d   = S_IDLE;
      cur_lvl_d = bkt_lvl_i;
      dcd_idx_d = dcd_idx_q;
      wr_en_d   = '0;
      value_d   = '0;
      lvl_d     = '0;
      done_d    = 1'b0;
      all_d     = 1'b0;
      ovf_d     = 1'b0;
      err_d     = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      lock_q    <= '0;
      cur_lvl_q <= '0;
      dcd_idx_q <= '0;
      wr_en_q   <= '0;
      value_q   <= '0;
      lvl_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      all_q     <= 1'b0;
      ovf_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      lock_q    <= lock_d;
      cur_lvl_q <= cur_lvl_d;
      dcd_idx_q <= dcd_idx_d;
      wr_en_q   <= wr_en_d;
      value_q   <= value_d;
      lvl_q     <= lvl_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      all_q     <= all_d;
      ovf_q     <= ovf_d;
      err_q     <= err_d;
    end
  end

  // The strobe must drop in the very cycle a backtrack or reset arrives, so it is
  // the one output qualified by current inputs.
  assign var_wr_en_o    = wr_en_q & {NUM_VARS{rst & ~bkt_en_i}};
  assign var_value_o    = value_q;
  assign var_lvl_o      = lvl_q;
  assign dcd_idx_o      = dcd_idx_q;
  assign cur_lvl_o      = cur_lvl_q;
  assign busy_o         = busy_q;
  assign done_dcd_o     = done_q;
  assign all_assigned_o = all_q;
  assign lvl_ovf_o      = ovf_q;
  assign idx_err_o      = err_q;

endmodule
